// File: rtl/mips_pkg.sv
// Shared decode constants, forwarding encodings and scoreboard types for the
// MIPS decode/issue stage.
package mips_pkg;

  localparam int RIDX_W = 5;
  localparam int OPC_W  = 6;

  localparam logic [5:0] OP_LD   = 6'b010100;
  localparam logic [5:0] OP_ST   = 6'b010101;
  localparam logic [5:0] OP_JMP  = 6'b011000;
  localparam logic [2:0] PFX_ALU = 3'b000;
  localparam logic [2:0] PFX_IMM = 3'b001;
  localparam logic [3:0] PFX_CJ  = 4'b0111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // One in-flight destination: slot 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic              vld;
    logic [RIDX_W-1:0] rg;
    logic              is_ld;
  } sb_slot_t;

  // Per-opcode control summary; b_is_rw marks ST, whose B source is RW.
  typedef struct packed {
    logic wr;
    logic rd_a;
    logic rd_b;
    logic b_is_rw;
    logic imm_sel;
    logic mem_en;
    logic mem_rw;
    logic is_ld;
  } dec_t;

  // Unlisted opcodes fall through as a NOP: no reads, no write, no memory.
  function automatic dec_t decode(input logic [OPC_W-1:0] op);
    dec_t d;
    d = '0;
    if (op[5:3] == PFX_ALU) begin
      d.wr = 1'b1; d.rd_a = 1'b1; d.rd_b = 1'b1;
    end else if (op[5:3] == PFX_IMM) begin
      d.wr = 1'b1; d.rd_a = 1'b1; d.imm_sel = 1'b1;
    end else if (op == OP_LD) begin
      d.wr = 1'b1; d.rd_a = 1'b1; d.imm_sel = 1'b1; d.mem_en = 1'b1; d.is_ld = 1'b1;
    end else if (op == OP_ST) begin
      d.rd_a = 1'b1; d.rd_b = 1'b1; d.b_is_rw = 1'b1; d.imm_sel = 1'b1;
      d.mem_en = 1'b1; d.mem_rw = 1'b1;
    end else if (op[5:2] == PFX_CJ) begin
      d.rd_a = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/pipe_hazard_sequencer_fwd_select.sv
// Forwarding select for one source operand: youngest matching in-flight
// destination wins; R0 and unread sources always come from the register file.
module fwd_select
  import mips_pkg::*;
(
  input  logic [RIDX_W-1:0]      src,
  input  logic                   rd_en,
  input  logic [2:0]             slot_vld,
  input  logic [2:0][RIDX_W-1:0] slot_rg,
  output logic [1:0]             sel
);

  // Priority search EX -> MEM -> WB.
  always_comb begin
    sel = FWD_RF;
    if (rd_en && (src != '0)) begin
      if (slot_vld[0] && (slot_rg[0] == src))      sel = FWD_EX;
      else if (slot_vld[1] && (slot_rg[1] == src)) sel = FWD_MEM;
      else if (slot_vld[2] && (slot_rg[2] == src)) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Decode/issue sequencer: scoreboard of EX/MEM/WB destinations, forwarding
// selects, single-cycle load-use stall and taken-branch squash.
module pipe_hazard_sequencer
  import mips_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic             br_taken,
  output logic             issue_valid,
  output logic [OP_W-1:0]  op_dec,
  output logic [REG_W-1:0] rw_dec,
  output logic [15:0]      imm,
  output logic [1:0]       mux_sel_A,
  output logic [1:0]       mux_sel_B,
  output logic             imm_sel,
  output logic             mem_en_ex,
  output logic             mem_rw_ex,
  output logic             stall
);

  localparam int NUM_SRC = 2;

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rw, ra, rb, src_b;
  dec_t             d;
  sb_slot_t [2:0]   sb;
  logic             hazard, accept;

  logic [2:0]                    slot_vld;
  logic [2:0][RIDX_W-1:0]        slot_rg;
  logic [NUM_SRC-1:0][RIDX_W-1:0] src_rg;
  logic [NUM_SRC-1:0]            src_en;
  logic [NUM_SRC-1:0][1:0]       sel;

  assign op    = ins[31:26];
  assign rw    = ins[25:21];
  assign ra    = ins[20:16];
  assign rb    = ins[15:11];
  assign d     = decode(op);
  assign src_b = d.b_is_rw ? rw : rb;

  // A load still in EX cannot forward; a taken branch discards the
  // instruction anyway, so it wins over the stall.
  assign hazard = ins_valid && sb[0].vld && sb[0].is_ld &&
                  ((d.rd_a && (ra == sb[0].rg)) || (d.rd_b && (src_b == sb[0].rg)));
  assign stall     = hazard && !br_taken;
  assign ins_ready = !stall;
  assign accept    = ins_valid && !stall && !br_taken;

  // Flatten scoreboard and operand sources for the select instances.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      slot_vld[i] = sb[i].vld;
      slot_rg[i]  = sb[i].rg;
    end
    src_rg[0] = ra;
    src_rg[1] = src_b;
    src_en[0] = d.rd_a;
    src_en[1] = d.rd_b;
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_select u_fwd (
      .src      (src_rg[g]),
      .rd_en    (src_en[g]),
      .slot_vld (slot_vld),
      .slot_rg  (slot_rg),
      .sel      (sel[g])
    );
  end

  // Scoreboard shift and registered decode outputs; fields hold on bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb          <= '0;
      issue_valid <= 1'b0;
      op_dec      <= '0;
      rw_dec      <= '0;
      imm         <= '0;
      mux_sel_A   <= FWD_RF;
      mux_sel_B   <= FWD_RF;
      imm_sel     <= 1'b0;
      mem_en_ex   <= 1'b0;
      mem_rw_ex   <= 1'b0;
    end else begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      if (accept && d.wr && (rw != '0))
        sb[0] <= '{vld: 1'b1, rg: rw, is_ld: d.is_ld};
      else
        sb[0] <= '0;
      issue_valid <= accept;
      mem_en_ex   <= accept && d.mem_en;
      if (accept) begin
        op_dec    <= op;
        rw_dec    <= rw;
        imm       <= ins[15:0];
        mux_sel_A <= sel[0];
        mux_sel_B <= sel[1];
        imm_sel   <= d.imm_sel;
        mem_rw_ex <= d.mem_rw;
      end
    end
  end

endmodule
